// File: rtl/snax_alu_accum_pkg.sv
// snax_alu_accum_pkg
//   Shared definitions for the ALU result accumulator: FSM state encoding
//   and the default values of the top-level parameters.
package snax_alu_accum_pkg;

  localparam int NUM_PE_DEF     = 4;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int CNT_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } state_e;

endpackage

// File: rtl/snax_alu_accum_lane.sv
// snax_alu_accum_lane
//   One lane of the reduction: a DataWidth register that either loads the
//   incoming value (first beat of a reduction) or adds it to the running sum.
//   The sum wraps modulo 2^DataWidth; there is no carry out of the lane.
// Ports
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset, clears the sum
//   en_i     : update the sum this cycle (input beat handshake)
//   first_i  : load instead of add
//   data_i   : lane value of the current beat
//   acc_o    : current sum
module snax_alu_accum_lane #(
  parameter int DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 first_i,
  input  logic [DataWidth-1:0] data_i,
  output logic [DataWidth-1:0] acc_o
);

  logic [DataWidth-1:0] acc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= first_i ? data_i : acc_q + data_i;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/snax_alu_accum.sv
// snax_alu_accum
//   Reduces K consecutive ALU result beats (NumPE lanes each) into a single
//   output vector by lane-wise wrapping addition, then hands it to the
//   streamer. K is programmed per reduction through the cfg handshake.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for a configuration; K==0 is accepted and dropped
//   ACCUM | accepting input beats until K have been summed
//   EMIT  | presenting the sum until the streamer takes it
//
// Ports
//   clk_i, rst_i             : clock, synchronous active-high reset
//   in_data_i/valid/ready    : input beats, lane i at [i*DataWidth +: DataWidth]
//   out_data_o/valid/ready   : reduced vector towards the streamer
//   cfg_len_i/valid/ready    : beat count K for the next reduction
//   busy_o                   : high whenever not IDLE
//   out_count_o              : completed output handshakes (wraps at 2^32)
module snax_alu_accum
  import snax_alu_accum_pkg::*;
#(
  parameter int NumPE     = NUM_PE_DEF,
  parameter int DataWidth = DATA_WIDTH_DEF,
  parameter int CntWidth  = CNT_WIDTH_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumPE*DataWidth-1:0] in_data_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [NumPE*DataWidth-1:0] out_data_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  input  logic [CntWidth-1:0]        cfg_len_i,
  input  logic                       cfg_valid_i,
  output logic                       cfg_ready_o,
  output logic                       busy_o,
  output logic [31:0]                out_count_o
);

  localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

  state_e                     state_q, state_d;
  logic [CntWidth-1:0]        cnt_q;
  logic [CntWidth-1:0]        k_q;
  logic [31:0]                out_count_q;
  logic [NumPE*DataWidth-1:0] acc;

  logic in_hs, cfg_hs, out_hs, first_beat, last_beat, cfg_nonzero;

  assign in_hs       = (state_q == ST_ACCUM) && in_valid_i;
  assign cfg_hs      = (state_q == ST_IDLE) && cfg_valid_i;
  assign out_hs      = (state_q == ST_EMIT) && out_ready_i;
  assign cfg_nonzero = (cfg_len_i != '0);
  assign first_beat  = (cnt_q == '0);
  // cnt_q never exceeds K-1, so K = 2^CntWidth-1 fits without wrapping.
  assign last_beat   = (cnt_q == (k_q - CntOne));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (cfg_hs && cfg_nonzero) state_d = ST_ACCUM;
      ST_ACCUM: if (in_hs && last_beat)    state_d = ST_EMIT;
      ST_EMIT:  if (out_hs)                state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      out_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (cfg_hs && cfg_nonzero) begin
        k_q   <= cfg_len_i;
        cnt_q <= '0;
      end else if (in_hs) begin
        cnt_q <= cnt_q + CntOne;
      end
      if (out_hs) begin
        out_count_q <= out_count_q + 32'd1;
      end
    end
  end

  for (genvar i = 0; i < NumPE; i++) begin : g_lane
    snax_alu_accum_lane #(
      .DataWidth(DataWidth)
    ) u_lane (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (in_hs),
      .first_i(first_beat),
      .data_i (in_data_i[i*DataWidth +: DataWidth]),
      .acc_o  (acc[i*DataWidth +: DataWidth])
    );
  end

  // Ready/valid outputs are pure state decodes; nothing here looks at a valid input.
  assign cfg_ready_o = (state_q == ST_IDLE);
  assign in_ready_o  = (state_q == ST_ACCUM);
  assign out_valid_o = (state_q == ST_EMIT);
  assign busy_o      = (state_q != ST_IDLE);
  assign out_data_o  = (state_q == ST_EMIT) ? acc : '0;
  assign out_count_o = out_count_q;

endmodule

// File: doc/snax_alu_accum.md
SNAX_ALU_ACCUM -- requirements
Module: snax_alu_accum

Interface
REQ-001 SHALL have parameter NumPE, default 4, number of lanes per beat.
REQ-002 SHALL have parameter DataWidth, default 64, bits per lane.
REQ-003 SHALL have parameter CntWidth, default 16, width of the beat-count configuration.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port in_data_i, input, NumPE*DataWidth, ALU result beat; lane i occupies bits [i*DataWidth +: DataWidth].
REQ-007 SHALL have port in_valid_i, input, 1, input beat valid.
REQ-008 SHALL have port in_ready_o, output, 1, input beat accepted.
REQ-009 SHALL have port out_data_o, output, NumPE*DataWidth, reduced vector to the streamer.
REQ-010 SHALL have port out_valid_o, output, 1, output valid.
REQ-011 SHALL have port out_ready_i, input, 1, streamer ready.
REQ-012 SHALL have port cfg_len_i, input, CntWidth, number of beats to reduce (K).
REQ-013 SHALL have port cfg_valid_i, input, 1, configuration valid.
REQ-014 SHALL have port cfg_ready_o, output, 1, configuration accepted.
REQ-015 SHALL have port busy_o, output, 1, high whenever the block is not IDLE.
REQ-016 SHALL have port out_count_o, output, 32, number of completed output handshakes.

Function
REQ-017 SHALL implement the FSM states IDLE, ACCUM and EMIT.
REQ-018 IDLE SHALL drive cfg_ready_o=1, in_ready_o=0, out_valid_o=0.
- On cfg_valid_i with cfg_len_i!=0: latch K, clear the beat counter, go to ACCUM.
- On cfg_valid_i with cfg_len_i==0: accept the handshake, stay in IDLE, produce no output.
REQ-019 ACCUM SHALL drive in_ready_o=1, cfg_ready_o=0, out_valid_o=0.
- On each input handshake, per lane, modulo 2^DataWidth: first beat loads acc=in; later beats set acc=acc+in.
- Overflow wraps, with no carry between lanes.
REQ-020 The beat counter SHALL increment on each ACCUM handshake. The handshake with counter==K-1 SHALL move the FSM to EMIT.
REQ-021 EMIT SHALL drive out_valid_o=1, out_data_o=acc, in_ready_o=0, cfg_ready_o=0.
- out_data_o SHALL hold stable until out_ready_i.
- On handshake: increment out_count_o (wraps at 2^32), go to IDLE.
REQ-022 Latency: final input handshake at cycle t -> out_valid_o high at t+1. With out_ready_i=1, the next cfg handshake is possible at t+2.
REQ-023 K=1 SHALL pass the single beat through unchanged, one cycle later.
REQ-024 K=2^CntWidth-1 SHALL be supported with no counter wrap.
REQ-025 in_valid_i in IDLE/EMIT and cfg_valid_i in ACCUM/EMIT SHALL be ignored without side effects.
REQ-026 ready outputs SHALL depend only on state, never combinationally on valid inputs.
REQ-027 Input bubbles (in_valid_i low) in ACCUM SHALL stall without changing acc or the counter.

Reset
REQ-028 On rst_i at a clock edge the block SHALL enter IDLE from any state, discarding partial sums. It SHALL clear acc, the counter, K and out_count_o to 0.
REQ-029 During and after reset the outputs SHALL be in_ready_o=0, out_valid_o=0, out_data_o=0, cfg_ready_o=1, busy_o=0, out_count_o=0.

Structure
REQ-030 Package snax_alu_accum_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-031 A sub-module snax_alu_accum_lane, one DataWidth load/add register instantiated NumPE times, SHALL be used.
REQ-032 Target size SHALL be 120-400 lines of RTL, with no memories.

Verification
REQ-033 Reset/pass-through: cfg K=1, then beat lanes {1,2,3,4} -> one cycle later out_data={1,2,3,4}, out_count_o=1.
REQ-034 Reduction: cfg K=3, beats {1,1,1,1},{2,2,2,2},{3,3,3,3} with in_valid_i gaps -> out={6,6,6,6}, exactly one output.
REQ-035 Wrap: K=2, lane0 beats 0xFFFF_FFFF_FFFF_FFFF and 2 -> lane0 out=1, lane1 unaffected.
REQ-036 Backpressure/zero-length: out_ready_i low for 5 cycles in EMIT -> out_data stable, in_ready_o=0, cfg_ready_o=0. A later cfg K=0 -> no output, busy_o stays 0.
REQ-037 Mid-op reset: K=4, assert rst_i after 2 beats -> IDLE, all outputs at reset values. A new K=1 with {9,9,9,9} -> out={9,9,9,9}.
